// File: rtl/lobster_pkg.sv
// Shared fetch types: FSM state encoding, default address width/reset PC, instruction word width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package lobster_pkg;

    localparam int          ADDR_WIDTH_DEF = 36;
    localparam logic [63:0] RESET_PC_DEF   = 64'hF800;
    localparam int          INST_WIDTH     = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/lobster_fifo.sv
// Synchronous FIFO with push/pop/flush; head entry is presented combinationally from storage.
// Latency: a pushed entry is visible at the head the cycle after the push edge.
// Backpressure: push is dropped only when full without a simultaneous pop; flush beats push/pop.
module lobster_fifo #(
    parameter int WIDTH = 100,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push  = push && (!full || pop);
    assign do_pop   = pop && !empty;

    // Storage is cleared on reset so the head reads zero out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (!flush && do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; flush empties without touching storage.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/lobster_fetch.sv
// Instruction fetch: single-outstanding SRAM reads into a small buffer, with redirect/flush.
// Latency: word appears on inst_valid one cycle after its mem_rdy cycle; 1 word/cycle streaming.
// Backpressure: stops requesting when buffer full; LOBSTER_FETCH_PERF_EN adds perf_stall counter.
module lobster_fetch
    import lobster_pkg::*;
#(
    parameter int                    ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int                    FIFO_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = RESET_PC_DEF[ADDR_WIDTH-1:0]
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  mem_ce,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_rdy,
    input  logic [INST_WIDTH-1:0] mem_data,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [INST_WIDTH-1:0] inst_data,
`ifdef LOBSTER_FETCH_PERF_EN
    output logic [31:0]           perf_stall,
`endif
    output logic [ADDR_WIDTH-1:0] inst_pc
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int FW = INST_WIDTH + ADDR_WIDTH;

    fetch_state_t          state;
    fetch_state_t          state_nxt;
    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic [ADDR_WIDTH-1:0] drain_addr;
    logic [ADDR_WIDTH-1:0] redirect_aligned;
    logic [CW-1:0]         count;
    logic [CW-1:0]         occ_after;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;
    logic [FW-1:0]         head;

    assign redirect_aligned = redirect_pc & ~ADDR_WIDTH'(7);
    assign inst_valid       = !empty;
    assign pop              = inst_valid && inst_ready && !redirect_valid;
    assign occ_after        = count + CW'(1) - CW'(pop);
    assign inst_data        = head[FW-1:ADDR_WIDTH];
    assign inst_pc          = head[ADDR_WIDTH-1:0];

    // While draining, the abandoned address is held so the SRAM sees a stable request.
    assign mem_addr = (state == ST_DRAIN) ? drain_addr : fetch_pc;

    // Next-state, request enable and buffer push decode.
    always_comb begin
        state_nxt = state;
        mem_ce    = 1'b0;
        push      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!redirect_valid && !full) state_nxt = ST_REQ;
            end
            ST_REQ: begin
                mem_ce = 1'b1;
                if (redirect_valid) begin
                    state_nxt = mem_rdy ? ST_IDLE : ST_DRAIN;
                end else if (mem_rdy) begin
                    push      = 1'b1;
                    state_nxt = (occ_after < CW'(FIFO_DEPTH)) ? ST_REQ : ST_IDLE;
                end
            end
            ST_DRAIN: begin
                mem_ce = 1'b1;
                if (mem_rdy) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Fetch address: redirect wins over the post-accept increment.
    always_ff @(posedge clk) begin
        if (rst)                 fetch_pc <= RESET_PC;
        else if (redirect_valid) fetch_pc <= redirect_aligned;
        else if (push)           fetch_pc <= fetch_pc + ADDR_WIDTH'(8);
    end

    // Capture the in-flight address when a redirect strands an unanswered request.
    always_ff @(posedge clk) begin
        if (rst)
            drain_addr <= RESET_PC;
        else if (state == ST_REQ && redirect_valid && !mem_rdy)
            drain_addr <= fetch_pc;
    end

`ifdef LOBSTER_FETCH_PERF_EN
    // Count cycles the SRAM holds off an issued request.
    always_ff @(posedge clk) begin
        if (rst)                    perf_stall <= '0;
        else if (mem_ce && !mem_rdy) perf_stall <= perf_stall + 32'd1;
    end
`endif

    lobster_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({mem_data, fetch_pc}),
        .pop       (pop),
        .flush     (redirect_valid),
        .pop_data  (head),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

endmodule

// File: tb/tb_lobster_fetch.sv
// Directed bench for lobster_fetch: streaming, fill/stall, redirect/drain, reset, PC wrap.
// Latency: n/a.
// Backpressure: exercised via inst_ready and mem_rdy patterns.
module tb_lobster_fetch;

    localparam int AW = 36;

    logic          clk = 1'b0;
    logic          rst;
    logic          mem_ce;
    logic [AW-1:0] mem_addr;
    logic          mem_rdy;
    logic [63:0]   mem_data;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic          inst_valid;
    logic          inst_ready;
    logic [63:0]   inst_data;
    logic [AW-1:0] inst_pc;
`ifdef LOBSTER_FETCH_PERF_EN
    logic [31:0]   perf_stall;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    lobster_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .mem_ce         (mem_ce),
        .mem_addr       (mem_addr),
        .mem_rdy        (mem_rdy),
        .mem_data       (mem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
`ifdef LOBSTER_FETCH_PERF_EN
        .perf_stall     (perf_stall),
`endif
        .inst_pc        (inst_pc)
    );

    // SRAM contents are a fixed function of the address.
    function automatic logic [63:0] mdat(input logic [AW-1:0] a);
        return {a[31:0] ^ 32'h5A5A_A5A5, a[31:0]};
    endfunction

    assign mem_data = mdat(mem_addr);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        redirect_valid = 1'b0;
        step;
        step;
        rst = 1'b0;
    endtask

    initial begin
        logic [AW-1:0] a;
        int pushes;
        int reqs;
        logic [AW-1:0] last_addr;

        rst = 1'b1;
        mem_rdy = 1'b1;
        inst_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;

        // Reset state
        step;
        step;
        chk("rst_ce",    64'(mem_ce),     64'd0);
        chk("rst_valid", 64'(inst_valid), 64'd0);
        chk("rst_addr",  64'(mem_addr),   64'hF800);
        chk("rst_data",  inst_data,       64'd0);
        chk("rst_pc",    64'(inst_pc),    64'd0);

        // Streaming with mem_rdy and inst_ready high
        rst = 1'b0;
        step;
        chk("str_ce0",    64'(mem_ce),     64'd1);
        chk("str_addr0",  64'(mem_addr),   64'hF800);
        chk("str_valid0", 64'(inst_valid), 64'd0);
        for (int i = 0; i < 4; i++) begin
            step;
            a = AW'(36'hF800 + 8 * i);
            chk("str_addr",  64'(mem_addr),   64'(a + AW'(8)));
            chk("str_valid", 64'(inst_valid), 64'd1);
            chk("str_pc",    64'(inst_pc),    64'(a));
            chk("str_data",  inst_data,       mdat(a));
        end

        // Fill with consumer stalled: exactly FIFO_DEPTH requests, then idle
        inst_ready = 1'b0;
        mem_rdy = 1'b1;
        do_reset;
        pushes = 0;
        for (int i = 0; i < 8; i++) begin
            step;
            if (mem_ce) pushes++;
        end
        chk("fill_pushes", 64'(pushes),     64'd4);
        chk("fill_ce",     64'(mem_ce),     64'd0);
        chk("fill_valid",  64'(inst_valid), 64'd1);
        chk("fill_pc",     64'(inst_pc),    64'hF800);
        chk("fill_data",   inst_data,       mdat(36'hF800));
        inst_ready = 1'b1;
        step;
        inst_ready = 1'b0;
        chk("pop_pc", 64'(inst_pc), 64'hF808);
        reqs = 0;
        last_addr = '0;
        for (int i = 0; i < 6; i++) begin
            step;
            if (mem_ce) begin
                reqs++;
                last_addr = mem_addr;
            end
        end
        chk("refill_reqs", 64'(reqs),      64'd1);
        chk("refill_addr", 64'(last_addr), 64'hF820);

        // From full, consume and fetch concurrently: order preserved, no gaps
        inst_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step;
            a = AW'(36'hF810 + 8 * i);
            chk("ord_valid", 64'(inst_valid), 64'd1);
            chk("ord_pc",    64'(inst_pc),    64'(a));
            chk("ord_data",  inst_data,       mdat(a));
        end

        // Redirect during a stalled request: drain then refetch at aligned target
        mem_rdy = 1'b0;
        inst_ready = 1'b1;
        do_reset;
        step;
        chk("drn_ce0",   64'(mem_ce),   64'd1);
        chk("drn_addr0", 64'(mem_addr), 64'hF800);
        for (int i = 0; i < 3; i++) begin
            step;
            chk("stall_addr",  64'(mem_addr),   64'hF800);
            chk("stall_valid", 64'(inst_valid), 64'd0);
        end
        redirect_valid = 1'b1;
        redirect_pc = AW'(36'h1003);
        step;
        redirect_valid = 1'b0;
        chk("drn_ce",    64'(mem_ce),     64'd1);
        chk("drn_addr",  64'(mem_addr),   64'hF800);
        chk("drn_valid", 64'(inst_valid), 64'd0);
        step;
        chk("drn_hold", 64'(mem_addr), 64'hF800);
        mem_rdy = 1'b1;
        step;
        chk("drn_done_ce",    64'(mem_ce),     64'd0);
        chk("drn_done_valid", 64'(inst_valid), 64'd0);
        step;
        chk("rd_ce",    64'(mem_ce),     64'd1);
        chk("rd_addr",  64'(mem_addr),   64'h1000);
        chk("rd_valid", 64'(inst_valid), 64'd0);
        step;
        chk("rd_word_valid", 64'(inst_valid), 64'd1);
        chk("rd_word_pc",    64'(inst_pc),    64'h1000);
        chk("rd_word_data",  inst_data,       mdat(36'h1000));

        // Reset while requesting with two entries buffered
        inst_ready = 1'b0;
        mem_rdy = 1'b1;
        do_reset;
        step;
        step;
        step;
        chk("pre_rst_pc",   64'(inst_pc),  64'hF800);
        chk("pre_rst_addr", 64'(mem_addr), 64'hF810);
        rst = 1'b1;
        step;
        chk("mid_rst_ce",    64'(mem_ce),     64'd0);
        chk("mid_rst_valid", 64'(inst_valid), 64'd0);
        chk("mid_rst_addr",  64'(mem_addr),   64'hF800);
        chk("mid_rst_pc",    64'(inst_pc),    64'd0);

        // Address wrap at the top of the address space
        inst_ready = 1'b1;
        mem_rdy = 1'b1;
        do_reset;
        redirect_valid = 1'b1;
        redirect_pc = AW'(36'hFFFFFFFF8);
        step;
        redirect_valid = 1'b0;
        chk("wrap_idle_ce", 64'(mem_ce),   64'd0);
        chk("wrap_tgt",     64'(mem_addr), 64'hFFFFFFFF8);
        step;
        chk("wrap_ce",   64'(mem_ce),   64'd1);
        chk("wrap_req",  64'(mem_addr), 64'hFFFFFFFF8);
        step;
        chk("wrap_next", 64'(mem_addr), 64'h0);
        chk("wrap_pc0",  64'(inst_pc),  64'hFFFFFFFF8);
        step;
        chk("wrap_pc1",  64'(inst_pc),  64'h0);

`ifdef LOBSTER_FETCH_PERF_EN
        // Stall counter over a single held request
        mem_rdy = 1'b0;
        do_reset;
        chk("perf_rst", 64'(perf_stall), 64'd0);
        step;
        for (int i = 0; i < 5; i++) step;
        mem_rdy = 1'b1;
        chk("perf_5", 64'(perf_stall), 64'd5);
        step;
        chk("perf_hold", 64'(perf_stall), 64'd5);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/lobster_fetch.md
LOBSTER_FETCH -- requirements
Module: lobster_fetch

Interface
REQ-001 ADDR_WIDTH, 36, physical address width in bits.
REQ-002 FIFO_DEPTH, 4, instruction buffer entries; power of two, 2..16.
REQ-003 RESET_PC, 'hF800, fetch address loaded on reset.
REQ-004 clk  in  1  sole clock; all state updates on posedge clk.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 mem_ce  out  1  SRAM read command-enable.
REQ-007 mem_addr  out  ADDR_WIDTH  SRAM read address.
REQ-008 mem_rdy  in  1  SRAM ready; mem_data valid in a cycle with mem_ce=1 and mem_rdy=1.
REQ-009 mem_data  in  64  SRAM read data.
REQ-010 redirect_valid  in  1  execute stage requests a fetch-stream change.
REQ-011 redirect_pc  in  ADDR_WIDTH  new fetch address.
REQ-012 inst_valid  out  1  head instruction available to execute.
REQ-013 inst_ready  in  1  execute stage accepts the head instruction.
REQ-014 inst_data  out  64  head instruction word.
REQ-015 inst_pc  out  ADDR_WIDTH  address of the head instruction word.

Function
REQ-016 The block SHALL hold one FSM: IDLE, REQ, DRAIN.
REQ-017 IDLE->REQ when (FIFO occupancy) < FIFO_DEPTH and no redirect this cycle; otherwise stay in IDLE.
REQ-018 In REQ and DRAIN, mem_ce=1 and mem_addr SHALL hold stable until mem_rdy=1; in IDLE, mem_ce=0.
REQ-019 REQ with mem_rdy=1 and no redirect: push {mem_data, fetch_pc} into the FIFO and set fetch_pc += 8, modulo 2^ADDR_WIDTH. Next state is REQ if a slot remains after this cycle's push/pop; otherwise IDLE.
REQ-020 Only one SRAM request SHALL be outstanding; a request is never abandoned before mem_rdy.
REQ-021 redirect_valid=1: flush the FIFO in the same edge and set fetch_pc <= {redirect_pc[ADDR_WIDTH-1:3], 3'b000}.
REQ-022 Redirect in REQ with mem_rdy=0 -> DRAIN. In DRAIN, wait for mem_rdy, discard the returned data, then go to IDLE.
REQ-023 Redirect in REQ with mem_rdy=1 -> discard the data and go to IDLE.
REQ-024 Redirect in DRAIN SHALL update fetch_pc only; the block stays in DRAIN.
REQ-025 inst_valid = FIFO not empty. A pop occurs when inst_valid && inst_ready && !redirect_valid.
REQ-026 Push and pop in the same cycle SHALL be allowed at any occupancy, including full; occupancy is unchanged.
REQ-027 Latency: first word is presented on inst_valid one cycle after the mem_rdy cycle. Throughput is one word per cycle when mem_rdy is held high.
REQ-028 inst_data and inst_pc SHALL be stable while inst_valid=1 and inst_ready=0.

Reset
REQ-029 rst=1 SHALL force on the next edge: state IDLE, fetch_pc=RESET_PC, FIFO empty, mem_ce=0, inst_valid=0.
REQ-030 rst SHALL take priority over redirect and over any in-flight request. A response arriving after reset is ignored because mem_ce=0.
REQ-031 Reset values: mem_addr=RESET_PC; inst_data=0; inst_pc=0.

Configuration
REQ-032 Macro LOBSTER_FETCH_PERF_EN, when defined, SHALL add output perf_stall  out  32, reset 0.
REQ-033 perf_stall SHALL increment by one, wrapping, in each cycle with mem_ce=1 and mem_rdy=0.
REQ-034 Without LOBSTER_FETCH_PERF_EN, the port and its counter SHALL be absent and all other behaviour identical.

Structure
REQ-035 Shared package lobster_pkg SHALL hold the fetch FSM state enum, the default ADDR_WIDTH, the default RESET_PC, and the instruction word width (64).
REQ-036 Instruction buffering SHALL be a sub-module lobster_fifo: a synchronous FIFO with push/pop/flush, width 64+ADDR_WIDTH, parameterised depth, full/empty/count outputs.

Verification
REQ-037 Reset release, mem_rdy tied to 1, inst_ready=1 -> mem_addr sequence F800, F808, F810...; inst_pc follows one cycle later with matching mem_data.
REQ-038 inst_ready=0, mem_rdy=1, FIFO_DEPTH=4 -> exactly 4 pushes, then mem_ce=0 and IDLE. One pop -> exactly one further request at F820.
REQ-039 mem_rdy=0 for 3 cycles, then redirect_pc=1003 -> state DRAIN, mem_addr held at the old address. Response discarded; next request at 1000; inst_valid=0 until that word returns.
REQ-040 FIFO full, inst_ready=1 and mem_rdy=1 in the same cycle -> occupancy stays 4 and order is preserved.
REQ-041 rst asserted while in REQ with 2 entries buffered -> next cycle mem_ce=0, inst_valid=0, mem_addr=F800.
REQ-042 With LOBSTER_FETCH_PERF_EN, mem_rdy low 5 cycles during one request -> perf_stall=5. fetch_pc=FFFFFFFF8 with ADDR_WIDTH=36 -> next request address 0.
